// File: rtl/layer11_train_sequencer_pkg.sv
// Shared definitions for the 11-class training sequencer: the fixed-point
// types seen by the learning layer, the class count and the sequencer states.
package layer11_train_sequencer_pkg;

  localparam int ZERO2ONE_W = 8;

  // Unsigned fraction in [0,1]: 8'h00 is 0.0, 8'hFF is the largest value.
  typedef logic [ZERO2ONE_W-1:0] zero2one_t;

  // Signed fraction used by the layer's weight arithmetic.
  typedef logic signed [ZERO2ONE_W:0] frac_t;

  localparam zero2one_t ZERO2ONE_MAX = '1;

  localparam int NUM_CLASSES = 11;
  localparam int CLASS_W     = 4;
  localparam int COUNT_W     = 16;

  // Largest label that names a real neuron; 11..15 are invalid labels.
  localparam logic [CLASS_W-1:0] MAX_LABEL = CLASS_W'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CLASSIFY,
    ST_LEARN,
    ST_REPORT
  } seq_state_t;

  // Target vector for training: full scale on the labelled neuron, zero
  // elsewhere, and all zero when the label does not name a neuron.
  function automatic zero2one_t [NUM_CLASSES-1:0] one_hot_target(
    input logic [CLASS_W-1:0] label
  );
    zero2one_t [NUM_CLASSES-1:0] target;
    target = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (label == CLASS_W'(i)) target[i] = ZERO2ONE_MAX;
    end
    return target;
  endfunction

endpackage

// File: rtl/layer11_train_sequencer_if.sv
// Sample stream into the sequencer: a valid/ready handshake carrying one
// feature vector, its target class and the train/inference flag.
interface layer11_train_sequencer_if
  import layer11_train_sequencer_pkg::*;
#(
  parameter int N = 16
);

  logic                    s_valid;
  logic                    s_ready;
  zero2one_t [N-1:0]       s_in;
  logic [CLASS_W-1:0]      s_label;
  logic                    s_train;

  modport master (
    output s_valid,
    output s_in,
    output s_label,
    output s_train,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_in,
    input  s_label,
    input  s_train,
    output s_ready
  );

endinterface

// File: rtl/layer11_train_sequencer_argmax.sv
// Combinational argmax over a vector of zero2one values. Only a strictly
// larger value displaces the current winner, so ties go to the lowest index.
module zero2one_argmax
  import layer11_train_sequencer_pkg::*;
#(
  parameter int LEN   = 11,
  parameter int IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  zero2one_t [LEN-1:0] vals,
  output logic [IDX_W-1:0]    idx
);

  zero2one_t best_val;

  // Linear scan from index 0 keeping the first occurrence of the maximum.
  always_comb begin
    idx      = '0;
    best_val = vals[0];
    for (int i = 1; i < LEN; i++) begin
      if (vals[i] > best_val) begin
        best_val = vals[i];
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/layer11_train_sequencer.sv
// Sequencer for an 11-neuron learning layer: accepts one sample, holds it on
// the layer inputs, waits for the layer to settle, picks the winning neuron,
// optionally pulses a learn strobe with a one-hot target, then reports the
// result and keeps running sample/correct statistics.
module layer11_train_sequencer
  import layer11_train_sequencer_pkg::*;
#(
  parameter int N      = 16,
  parameter int SETTLE = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,

  layer11_train_sequencer_if.slave      s_if,

  output logic                          l_valid,
  output logic                          l_learn,
  output zero2one_t [N-1:0]             l_in,
  output zero2one_t [NUM_CLASSES-1:0]   l_expected_out,
  input  zero2one_t [NUM_CLASSES-1:0]   l_out,

  output logic                          r_valid,
  output logic [CLASS_W-1:0]            r_class,
  output logic                          r_correct,
  output logic                          r_bad_label,

  input  logic                          clear_stats,
  output logic [COUNT_W-1:0]            sample_count,
  output logic [COUNT_W-1:0]            correct_count
);

  localparam int CNT_W = 4;

  seq_state_t           state_q;
  seq_state_t           state_d;
  logic                 s_ready_c;
  logic                 accept;
  logic                 label_ok;

  zero2one_t [N-1:0]    hold_in_q;
  logic [CLASS_W-1:0]   hold_label_q;
  logic                 hold_train_q;
  logic [CNT_W-1:0]     settle_cnt_q;

  logic [CLASS_W-1:0]   win_idx;
  logic [CLASS_W-1:0]   r_class_q;
  logic                 r_correct_q;
  logic                 r_bad_label_q;

  logic [COUNT_W-1:0]   sample_cnt_q;
  logic [COUNT_W-1:0]   correct_cnt_q;

  assign accept   = s_if.s_valid && s_ready_c;
  assign label_ok = (hold_label_q <= MAX_LABEL);

  assign s_if.s_ready   = s_ready_c;
  assign l_in           = hold_in_q;
  assign l_expected_out = one_hot_target(hold_label_q);
  assign r_class        = r_class_q;
  assign r_correct      = r_correct_q;
  assign r_bad_label    = r_bad_label_q;
  assign sample_count   = sample_cnt_q;
  assign correct_count  = correct_cnt_q;

  zero2one_argmax #(
    .LEN   (NUM_CLASSES),
    .IDX_W (CLASS_W)
  ) u_argmax (
    .vals (l_out),
    .idx  (win_idx)
  );

  // State register; reset abandons any sample in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d   = state_q;
    s_ready_c = 1'b0;
    l_valid   = 1'b0;
    l_learn   = 1'b0;
    r_valid   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s_ready_c = 1'b1;
        if (s_if.s_valid) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        l_valid = 1'b1;
        if (settle_cnt_q == '0) state_d = ST_CLASSIFY;
      end
      ST_CLASSIFY: begin
        l_valid = 1'b1;
        state_d = (hold_train_q && label_ok) ? ST_LEARN : ST_REPORT;
      end
      ST_LEARN: begin
        l_valid = 1'b1;
        l_learn = 1'b1;
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        r_valid = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the accepted sample and load the settle countdown with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_in_q    <= '0;
      hold_label_q <= '0;
      hold_train_q <= 1'b0;
      settle_cnt_q <= '0;
    end else if (accept) begin
      hold_in_q    <= s_if.s_in;
      hold_label_q <= s_if.s_label;
      hold_train_q <= s_if.s_train;
      settle_cnt_q <= CNT_W'(SETTLE - 1);
    end else if (state_q == ST_SETTLE && settle_cnt_q != '0) begin
      settle_cnt_q <= settle_cnt_q - CNT_W'(1);
    end
  end

  // Latch the classification at the end of CLASSIFY so it stays stable
  // through LEARN and REPORT and until the next sample is classified.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_class_q     <= '0;
      r_correct_q   <= 1'b0;
      r_bad_label_q <= 1'b0;
    end else if (state_q == ST_CLASSIFY) begin
      r_class_q     <= win_idx;
      r_correct_q   <= label_ok && (win_idx == hold_label_q);
      r_bad_label_q <= !label_ok;
    end
  end

  // Saturating statistics; a clear wins over the REPORT increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_cnt_q  <= '0;
      correct_cnt_q <= '0;
    end else if (clear_stats) begin
      sample_cnt_q  <= '0;
      correct_cnt_q <= '0;
    end else if (state_q == ST_REPORT) begin
      if (sample_cnt_q != '1) sample_cnt_q <= sample_cnt_q + COUNT_W'(1);
      if (r_correct_q && correct_cnt_q != '1)
        correct_cnt_q <= correct_cnt_q + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_layer11_train_sequencer.sv
// Self-checking bench for layer11_train_sequencer: a table of directed
// samples, randomized samples against a behavioural model, and hand-written
// sequences for clear/report collision, saturation and mid-sample reset.
module tb_layer11_train_sequencer;
  import layer11_train_sequencer_pkg::*;

  localparam int N          = 16;
  localparam int SETTLE_CYC = 2;
  localparam int MAX_WAIT   = 40;
  localparam int NUM_VECS   = 7;
  localparam int NUM_RAND   = 24;

  typedef zero2one_t [NUM_CLASSES-1:0] outs_t;
  typedef zero2one_t [N-1:0]           feat_t;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               l_valid;
  logic               l_learn;
  feat_t              l_in;
  outs_t              l_expected_out;
  outs_t              l_out;
  logic               r_valid;
  logic [CLASS_W-1:0] r_class;
  logic               r_correct;
  logic               r_bad_label;
  logic               clear_stats;
  logic [15:0]        sample_count;
  logic [15:0]        correct_count;

  layer11_train_sequencer_if #(.N(N)) s_bus ();

  layer11_train_sequencer #(
    .N      (N),
    .SETTLE (SETTLE_CYC)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .s_if           (s_bus),
    .l_valid        (l_valid),
    .l_learn        (l_learn),
    .l_in           (l_in),
    .l_expected_out (l_expected_out),
    .l_out          (l_out),
    .r_valid        (r_valid),
    .r_class        (r_class),
    .r_correct      (r_correct),
    .r_bad_label    (r_bad_label),
    .clear_stats    (clear_stats),
    .sample_count   (sample_count),
    .correct_count  (correct_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int model_samples = 0;
  int model_correct = 0;

  typedef struct {
    outs_t        outs;
    logic [3:0]   label;
    logic         train;
    logic [3:0]   exp_class;
    logic         exp_correct;
    logic         exp_bad;
    logic         exp_learn;
  } vec_t;

  typedef struct {
    logic         got_ready;
    int           rvalid_cycle;
    int           learn_cycle;
    int           learn_pulses;
    int           lvalid_cycles;
    logic         lin_ok;
    logic [3:0]   cls;
    logic         cor;
    logic         bad;
    outs_t        exp_out;
  } res_t;

  vec_t vecs [NUM_VECS];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic outs_t mk_outs(input int hot, input zero2one_t hv,
                                    input zero2one_t base);
    outs_t o;
    for (int i = 0; i < NUM_CLASSES; i++) o[i] = base;
    if (hot >= 0 && hot < NUM_CLASSES) o[hot] = hv;
    return o;
  endfunction

  function automatic feat_t rand_feat();
    feat_t f;
    for (int i = 0; i < N; i++) f[i] = zero2one_t'($urandom);
    return f;
  endfunction

  // Reference winner: find the maximum value, then the first index holding it.
  function automatic logic [3:0] model_winner(input outs_t outs);
    int max_v = 0;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (int'(outs[i]) > max_v) max_v = int'(outs[i]);
    for (int i = 0; i < NUM_CLASSES; i++)
      if (int'(outs[i]) == max_v) return 4'(i);
    return 4'd0;
  endfunction

  function automatic int model_inc(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  // Offer one sample, follow it to its result and step past the REPORT edge.
  task automatic applyStimulus(input feat_t feat, input outs_t outs,
                               input logic [3:0] lbl, input logic trn,
                               input logic clr_at_report, output res_t res);
    res.got_ready     = 1'b0;
    res.rvalid_cycle  = -1;
    res.learn_cycle   = -1;
    res.learn_pulses  = 0;
    res.lvalid_cycles = 0;
    res.lin_ok        = 1'b1;
    res.cls           = '0;
    res.cor           = 1'b0;
    res.bad           = 1'b0;
    res.exp_out       = '0;
    l_out          = outs;
    s_bus.s_in     = feat;
    s_bus.s_label  = lbl;
    s_bus.s_train  = trn;
    s_bus.s_valid  = 1'b1;
    for (int w = 0; w < MAX_WAIT && !s_bus.s_ready; w++) @(negedge clock);
    if (!s_bus.s_ready) begin
      s_bus.s_valid = 1'b0;
      return;
    end
    res.got_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    s_bus.s_valid = 1'b0;
    for (int cyc = 1; cyc <= MAX_WAIT; cyc++) begin
      if (l_valid) begin
        res.lvalid_cycles++;
        if (l_in !== feat) res.lin_ok = 1'b0;
      end
      if (l_learn) begin
        res.learn_pulses++;
        res.learn_cycle = cyc;
      end
      if (r_valid) begin
        res.rvalid_cycle = cyc;
        res.cls     = r_class;
        res.cor     = r_correct;
        res.bad     = r_bad_label;
        res.exp_out = l_expected_out;
        if (clr_at_report) clear_stats = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clear_stats = 1'b0;
        break;
      end
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Compare one completed sample against the behavioural model.
  task automatic verifySample(input string tag, input feat_t feat,
                              input outs_t outs, input logic [3:0] lbl,
                              input logic trn, input logic clr, input res_t res);
    logic [3:0] e_cls;
    logic       e_ok;
    logic       e_cor;
    logic       e_learn;
    outs_t      e_target;
    e_cls    = model_winner(outs);
    e_ok     = (int'(lbl) < NUM_CLASSES);
    e_cor    = e_ok && (e_cls == lbl);
    e_learn  = trn && e_ok;
    e_target = '0;
    if (e_ok) e_target[lbl] = 8'hFF;
    if (clr) begin
      model_samples = 0;
      model_correct = 0;
    end else begin
      model_samples = model_inc(model_samples);
      if (e_cor) model_correct = model_inc(model_correct);
    end
    checkOutput({tag, "_ready"}, 128'(res.got_ready), 128'(1));
    checkOutput({tag, "_latency"}, 128'(res.rvalid_cycle),
                128'(SETTLE_CYC + 2 + (e_learn ? 1 : 0)));
    checkOutput({tag, "_learn_pulses"}, 128'(res.learn_pulses), 128'(e_learn ? 1 : 0));
    checkOutput({tag, "_learn_cycle"}, 128'(res.learn_cycle),
                128'(e_learn ? SETTLE_CYC + 2 : -1));
    checkOutput({tag, "_lvalid_cycles"}, 128'(res.lvalid_cycles),
                128'(SETTLE_CYC + 1 + (e_learn ? 1 : 0)));
    checkOutput({tag, "_l_in"}, 128'(res.lin_ok), 128'(1));
    checkOutput({tag, "_class"}, 128'(res.cls), 128'(e_cls));
    checkOutput({tag, "_correct"}, 128'(res.cor), 128'(e_cor));
    checkOutput({tag, "_bad_label"}, 128'(res.bad), 128'(!e_ok));
    checkOutput({tag, "_expected_out"}, 128'(res.exp_out), 128'(e_target));
    checkOutput({tag, "_sample_count"}, 128'(sample_count), 128'(model_samples));
    checkOutput({tag, "_correct_count"}, 128'(correct_count), 128'(model_correct));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res_t       res;
    feat_t      feat;
    outs_t      outs;
    logic [3:0] lbl;
    logic       trn;
    int         rv_seen;
    int         learn_seen;

    s_bus.s_valid = 1'b0;
    s_bus.s_in    = '0;
    s_bus.s_label = '0;
    s_bus.s_train = 1'b0;
    l_out         = '0;
    clear_stats   = 1'b0;

    vecs[0] = '{outs: mk_outs(3, 8'hC0, 8'h20), label: 4'd3, train: 1'b1,
                exp_class: 4'd3, exp_correct: 1'b1, exp_bad: 1'b0, exp_learn: 1'b1};
    vecs[1] = '{outs: mk_outs(7, 8'hE0, 8'h40), label: 4'd5, train: 1'b0,
                exp_class: 4'd7, exp_correct: 1'b0, exp_bad: 1'b0, exp_learn: 1'b0};
    vecs[2] = '{outs: mk_outs(-1, 8'h00, 8'h55), label: 4'd0, train: 1'b1,
                exp_class: 4'd0, exp_correct: 1'b1, exp_bad: 1'b0, exp_learn: 1'b1};
    vecs[3] = '{outs: mk_outs(2, 8'hA0, 8'h10), label: 4'd12, train: 1'b1,
                exp_class: 4'd2, exp_correct: 1'b0, exp_bad: 1'b1, exp_learn: 1'b0};
    vecs[4] = '{outs: mk_outs(10, 8'hFF, 8'hFE), label: 4'd10, train: 1'b1,
                exp_class: 4'd10, exp_correct: 1'b1, exp_bad: 1'b0, exp_learn: 1'b1};
    vecs[5] = '{outs: mk_outs(4, 8'h81, 8'h80), label: 4'd11, train: 1'b0,
                exp_class: 4'd4, exp_correct: 1'b0, exp_bad: 1'b1, exp_learn: 1'b0};
    vecs[6] = '{outs: mk_outs(6, 8'h90, 8'h30), label: 4'd9, train: 1'b1,
                exp_class: 4'd6, exp_correct: 1'b0, exp_bad: 1'b0, exp_learn: 1'b1};
    vecs[6].outs[9] = 8'h90;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_l_valid", 128'(l_valid), 128'(0));
    checkOutput("rst_r_valid", 128'(r_valid), 128'(0));
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("rst_s_ready", 128'(s_bus.s_ready), 128'(1));
    checkOutput("rst_l_learn", 128'(l_learn), 128'(0));
    checkOutput("rst_l_in", 128'(l_in), 128'(0));
    checkOutput("rst_r_class", 128'(r_class), 128'(0));
    checkOutput("rst_r_correct", 128'(r_correct), 128'(0));
    checkOutput("rst_r_bad_label", 128'(r_bad_label), 128'(0));
    checkOutput("rst_sample_count", 128'(sample_count), 128'(0));
    checkOutput("rst_correct_count", 128'(correct_count), 128'(0));

    // Directed table.
    for (int v = 0; v < NUM_VECS; v++) begin
      feat = rand_feat();
      applyStimulus(feat, vecs[v].outs, vecs[v].label, vecs[v].train, 1'b0, res);
      checkOutput($sformatf("vec%0d_tbl_class", v), 128'(res.cls), 128'(vecs[v].exp_class));
      checkOutput($sformatf("vec%0d_tbl_correct", v), 128'(res.cor), 128'(vecs[v].exp_correct));
      checkOutput($sformatf("vec%0d_tbl_bad", v), 128'(res.bad), 128'(vecs[v].exp_bad));
      checkOutput($sformatf("vec%0d_tbl_learn", v), 128'(res.learn_pulses),
                  128'(vecs[v].exp_learn ? 1 : 0));
      verifySample($sformatf("vec%0d", v), feat, vecs[v].outs, vecs[v].label,
                   vecs[v].train, 1'b0, res);
    end

    // Randomized samples with frequent ties.
    for (int r = 0; r < NUM_RAND; r++) begin
      feat = rand_feat();
      for (int i = 0; i < NUM_CLASSES; i++)
        outs[i] = zero2one_t'($urandom_range(0, 3) * 64);
      lbl = 4'($urandom_range(0, 15));
      trn = 1'($urandom_range(0, 1));
      if (lbl <= 4'd10 && $urandom_range(0, 1) == 1) outs[lbl] = 8'hFF;
      applyStimulus(feat, outs, lbl, trn, 1'b0, res);
      verifySample($sformatf("rand%0d", r), feat, outs, lbl, trn, 1'b0, res);
    end

    // clear_stats coincident with REPORT wins over the increment.
    feat = rand_feat();
    outs = mk_outs(1, 8'hF0, 8'h00);
    applyStimulus(feat, outs, 4'd1, 1'b1, 1'b1, res);
    verifySample("clr_report", feat, outs, 4'd1, 1'b1, 1'b1, res);

    // clear_stats while idle.
    applyStimulus(feat, outs, 4'd1, 1'b0, 1'b0, res);
    verifySample("pre_clr", feat, outs, 4'd1, 1'b0, 1'b0, res);
    clear_stats = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear_stats = 1'b0;
    model_samples = 0;
    model_correct = 0;
    checkOutput("clr_idle_sample_count", 128'(sample_count), 128'(0));
    checkOutput("clr_idle_correct_count", 128'(correct_count), 128'(0));

    // Saturation: preload both counters one short of full scale.
    force dut.sample_cnt_q  = 16'hFFFE;
    force dut.correct_cnt_q = 16'hFFFE;
    @(posedge clock);
    @(negedge clock);
    release dut.sample_cnt_q;
    release dut.correct_cnt_q;
    model_samples = 65534;
    model_correct = 65534;
    checkOutput("preload_sample_count", 128'(sample_count), 128'(16'hFFFE));
    for (int k = 0; k < 2; k++) begin
      feat = rand_feat();
      outs = mk_outs(8, 8'hC8, 8'h08);
      applyStimulus(feat, outs, 4'd8, 1'b0, 1'b0, res);
      verifySample($sformatf("sat%0d", k), feat, outs, 4'd8, 1'b0, 1'b0, res);
    end
    checkOutput("sat_sample_count", 128'(sample_count), 128'(16'hFFFF));
    checkOutput("sat_correct_count", 128'(correct_count), 128'(16'hFFFF));

    // Reset during SETTLE aborts the sample.
    l_out         = mk_outs(3, 8'hC0, 8'h20);
    s_bus.s_in    = rand_feat();
    s_bus.s_label = 4'd3;
    s_bus.s_train = 1'b1;
    s_bus.s_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    s_bus.s_valid = 1'b0;
    checkOutput("abort_in_settle", 128'(l_valid), 128'(1));
    reset_n = 1'b0;
    #1;
    checkOutput("abort_l_valid_now", 128'(l_valid), 128'(0));
    checkOutput("abort_counts_now", 128'({sample_count, correct_count}), 128'(0));
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    rv_seen    = 0;
    learn_seen = 0;
    for (int c = 0; c < SETTLE_CYC + 6; c++) begin
      @(negedge clock);
      if (r_valid) rv_seen++;
      if (l_learn) learn_seen++;
    end
    model_samples = 0;
    model_correct = 0;
    checkOutput("abort_no_r_valid", 128'(rv_seen), 128'(0));
    checkOutput("abort_no_l_learn", 128'(learn_seen), 128'(0));
    checkOutput("abort_s_ready", 128'(s_bus.s_ready), 128'(1));
    checkOutput("abort_sample_count", 128'(sample_count), 128'(0));
    checkOutput("abort_correct_count", 128'(correct_count), 128'(0));
    checkOutput("abort_l_in_cleared", 128'(l_in), 128'(0));

    // Normal operation resumes after the abort.
    feat = rand_feat();
    outs = mk_outs(5, 8'hB0, 8'h30);
    applyStimulus(feat, outs, 4'd5, 1'b1, 1'b0, res);
    verifySample("post_abort", feat, outs, 4'd5, 1'b1, 1'b0, res);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer11_train_sequencer.md
LAYER11_TRAIN_SEQUENCER -- requirements
Module: layer11_train_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, number of inputs per sample; parameter SETTLE, default 2, cycles allowed for layer output to settle (1..15).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_valid  input  1  sample offered; s_ready  output  1  sequencer accepts.
REQ-005 SHALL have port s_in  input  zero2one_t[N]  sample features; s_label  input  4  target class 0..10; s_train  input  1  1 = train, 0 = inference only.
REQ-006 SHALL have port l_valid  output  1; l_learn  output  1; l_in  output  zero2one_t[N]; l_expected_out  output  zero2one_t[11]  drive the 11-neuron learning layer.
REQ-007 SHALL have port l_out  input  zero2one_t[11]  layer outputs.
REQ-008 SHALL have port r_valid  output  1  result pulse; r_class  output  4  winning neuron; r_correct  output  1; r_bad_label  output  1.
REQ-009 SHALL have port clear_stats  input  1; sample_count  output  16; correct_count  output  16.

Function
REQ-010 FSM states SHALL be IDLE, SETTLE, CLASSIFY, LEARN, REPORT.
REQ-011 s_ready SHALL be 1 only in IDLE; transfer on s_valid&&s_ready captures s_in, s_label, s_train into holding registers and moves to SETTLE.
REQ-012 l_in SHALL equal the holding register at all times; l_valid SHALL be 1 in SETTLE, CLASSIFY, LEARN.
REQ-013 SETTLE SHALL last exactly SETTLE cycles via down-counter, then CLASSIFY.
REQ-014 CLASSIFY (1 cycle) SHALL register r_class = argmax(l_out), ties resolved to lowest index.
REQ-015 l_expected_out SHALL be one-hot: index s_label = zero2one maximum constant, all others zero; all zero when label >10.
REQ-016 From CLASSIFY: go LEARN if s_train=1 and label<=10, else REPORT.
REQ-017 LEARN SHALL assert l_learn for exactly 1 cycle, then REPORT; l_learn SHALL be 0 in every other state.
REQ-018 REPORT SHALL assert r_valid for 1 cycle with r_correct = (r_class==label && label<=10), r_bad_label = (label>10), then IDLE.
REQ-019 Total latency s_valid accept to r_valid SHALL be SETTLE+2 cycles (inference) or SETTLE+3 (train).
REQ-020 On REPORT, sample_count +1 and correct_count +r_correct, both saturating at 16'hFFFF.
REQ-021 clear_stats SHALL zero both counters next edge and take priority over a simultaneous REPORT increment.
REQ-022 r_class, r_correct, r_bad_label SHALL hold until next CLASSIFY/REPORT; no back-pressure on results.

Reset
REQ-023 reset_n low SHALL immediately force IDLE, s_ready=1 after release, l_valid=0, l_learn=0, r_valid=0, r_class=0, r_correct=0, r_bad_label=0, counters=0, holding registers=0.
REQ-024 Reset mid-operation SHALL abort the sample with no r_valid and no l_learn pulse.

Structure
REQ-025 zero2one_t, frac_t and the zero2one maximum constant SHALL come from the shared defs package; state enum and NUM_CLASSES=11 SHALL be added there.
REQ-026 Argmax SHALL be a separate combinational sub-module zero2one_argmax (parameter LEN).

Verification
REQ-027 Train sample, label 3, l_out[3] largest -> l_learn one pulse at cycle SETTLE+2, r_valid at SETTLE+3, r_class=3, r_correct=1, correct_count=1.
REQ-028 Inference, label 5, l_out[7] largest -> no l_learn, r_valid at SETTLE+2, r_class=7, r_correct=0, sample_count=1.
REQ-029 l_out all equal -> r_class=0.
REQ-030 Label 12, s_train=1 -> no l_learn, l_expected_out all zero, r_bad_label=1, r_correct=0.
REQ-031 reset_n low during SETTLE -> no r_valid, counters 0, s_ready=1 after release; clear_stats coincident with REPORT -> counters 0.
REQ-032 Preload sample_count 16'hFFFF via 65535 samples -> one more sample keeps 16'hFFFF.
